// File: rtl/config_writer_pkg.sv
// Shared synth definitions: voice-operator ID type and the three-byte register-writer packet.
package config_writer_pkg;

  localparam int unsigned NUM_VOICE_OPERATORS = 256;
  localparam int unsigned VOICE_ID_WIDTH      = $clog2(NUM_VOICE_OPERATORS);

  typedef logic [VOICE_ID_WIDTH-1:0] VoiceOperatorID_t;

  // Packet layout: address, data high, data low.
  localparam int unsigned PACKET_BYTES = 3;

  typedef enum logic [1:0] {
    S_ADDR = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } writer_state_t;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_HIGH = 2'b01;
  localparam logic [1:0] WE_LOW  = 2'b10;

  function automatic writer_state_t next_packet_state(input writer_state_t st);
    unique case (st)
      S_ADDR:  next_packet_state = S_HIGH;
      S_HIGH:  next_packet_state = S_LOW;
      default: next_packet_state = S_ADDR;
    endcase
  endfunction

endpackage

// File: rtl/config_writer.sv
// Turns a host byte stream of (addr, hi, lo) packets into phase-step byte-lane writes.
// Optional inter-byte timeout enabled by defining CONFIG_WRITER_TIMEOUT_EN.
module config_writer
  import config_writer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned ADDR_WIDTH     = VOICE_ID_WIDTH
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic [7:0]            i_RxData,
  input  logic                  i_RxValid,
  output logic                  o_RxReady,
  output logic [1:0]            o_PhaseStepConfigWriteEnable,
  output logic [ADDR_WIDTH-1:0] o_PhaseStepConfigWriteAddr,
  output logic [7:0]            o_PhaseStepConfigWriteData,
  output logic                  o_Busy,
  output logic                  o_FrameError
);

  localparam int unsigned CopyW = (ADDR_WIDTH < 8) ? ADDR_WIDTH : 8;

  writer_state_t         r_State;
  writer_state_t         w_NextState;
  logic                  r_RxReady;
  logic [ADDR_WIDTH-1:0] r_AddrLatch;
  logic [1:0]            r_WriteEnable;
  logic [ADDR_WIDTH-1:0] r_WriteAddr;
  logic [7:0]            r_WriteData;
  logic                  r_FrameError;

  logic                  w_Accept;
  logic                  w_Busy;
  logic                  w_Expire;
  logic [1:0]            w_WriteEnable;
  logic                  w_FrameError;
  logic [ADDR_WIDTH-1:0] w_AddrByte;

  assign w_Accept   = i_RxValid & r_RxReady;
  assign w_Busy     = (r_State != S_ADDR);
  // Upper address bits beyond the operator ID width are simply dropped.
  assign w_AddrByte = ADDR_WIDTH'(i_RxData[CopyW-1:0]);

`ifdef CONFIG_WRITER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] r_TimeoutCnt;

  // An accepted byte in the expiry cycle wins over the timeout.
  assign w_Expire = w_Busy && !w_Accept && (r_TimeoutCnt == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_TimeoutCnt <= '0;
    end else if (w_Accept || !w_Busy || w_Expire) begin
      r_TimeoutCnt <= '0;
    end else begin
      r_TimeoutCnt <= r_TimeoutCnt + 1'b1;
    end
  end
`else
  assign w_Expire = 1'b0;
`endif

  always_comb begin
    w_NextState   = r_State;
    w_WriteEnable = WE_NONE;
    w_FrameError  = 1'b0;
    if (w_Accept) begin
      w_NextState = next_packet_state(r_State);
      unique case (r_State)
        S_HIGH:  w_WriteEnable = WE_HIGH;
        S_LOW:   w_WriteEnable = WE_LOW;
        default: w_WriteEnable = WE_NONE;
      endcase
    end else if (w_Expire) begin
      w_NextState  = S_ADDR;
      w_FrameError = 1'b1;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_State       <= S_ADDR;
      r_RxReady     <= 1'b0;
      r_AddrLatch   <= '0;
      r_WriteEnable <= WE_NONE;
      r_WriteAddr   <= '0;
      r_WriteData   <= '0;
      r_FrameError  <= 1'b0;
    end else begin
      r_State       <= w_NextState;
      r_RxReady     <= 1'b1;
      r_WriteEnable <= w_WriteEnable;
      r_FrameError  <= w_FrameError;
      if (w_Accept && (r_State == S_ADDR)) begin
        r_AddrLatch <= w_AddrByte;
      end
      if (w_WriteEnable != WE_NONE) begin
        r_WriteAddr <= r_AddrLatch;
        r_WriteData <= i_RxData;
      end
    end
  end

  assign o_RxReady                    = r_RxReady;
  assign o_PhaseStepConfigWriteEnable = r_WriteEnable;
  assign o_PhaseStepConfigWriteAddr   = r_WriteAddr;
  assign o_PhaseStepConfigWriteData   = r_WriteData;
  assign o_Busy                       = w_Busy;
  assign o_FrameError                 = r_FrameError;

endmodule

// File: tb/tb_config_writer.sv
// Scoreboard bench for config_writer: packet-position model feeds expected strobes to a monitor.
module tb_config_writer;

  localparam int unsigned TIMEOUT = 16;

  typedef struct packed {
    logic [1:0] we;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  logic       i_Clock;
  logic       i_Reset;
  logic [7:0] i_RxData;
  logic       i_RxValid;
  logic       o_RxReady;
  logic [1:0] o_WE;
  logic [7:0] o_Addr;
  logic [7:0] o_Data;
  logic       o_Busy;
  logic       o_FrameError;

  config_writer #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .ADDR_WIDTH    (8)
  ) u_dut (
    .i_Clock                     (i_Clock),
    .i_Reset                     (i_Reset),
    .i_RxData                    (i_RxData),
    .i_RxValid                   (i_RxValid),
    .o_RxReady                   (o_RxReady),
    .o_PhaseStepConfigWriteEnable(o_WE),
    .o_PhaseStepConfigWriteAddr  (o_Addr),
    .o_PhaseStepConfigWriteData  (o_Data),
    .o_Busy                      (o_Busy),
    .o_FrameError                (o_FrameError)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];

  // Reference model: byte position within the packet, latched address, idle count.
  int         m_pos   = 0;
  int         m_idle  = 0;
  logic [7:0] m_addr  = 8'h00;
  logic       m_ready = 1'b0;
  logic       m_err   = 1'b0;
  logic [7:0] m_last_addr = 8'h00;
  logic [7:0] m_last_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0;
    m_idle = 0;
    m_addr = 8'h00;
    m_ready = 1'b0;
    m_err = 1'b0;
    m_last_addr = 8'h00;
    m_last_data = 8'h00;
    q.delete();
  endtask

  // One clock cycle of stimulus; called and returns just after a falling edge.
  task automatic cycle(input logic v, input logic [7:0] d);
    logic acc;
    exp_t e;
    i_RxValid = v;
    i_RxData  = d;
    acc = v && m_ready;
    @(posedge i_Clock);
    m_err   = 1'b0;
    m_ready = 1'b1;
    if (acc) begin
      if (m_pos == 0) begin
        m_addr = d;
      end else begin
        e.we   = (m_pos == 1) ? 2'b01 : 2'b10;
        e.addr = m_addr;
        e.data = d;
        q.push_back(e);
      end
      m_pos  = (m_pos + 1) % 3;
      m_idle = 0;
    end else if (m_pos != 0) begin
      m_idle++;
`ifdef CONFIG_WRITER_TIMEOUT_EN
      if (m_idle >= TIMEOUT) begin
        m_pos  = 0;
        m_idle = 0;
        m_err  = 1'b1;
      end
`endif
    end
    @(negedge i_Clock);
  endtask

  task automatic send(input logic [7:0] d, input int gap);
    cycle(1'b1, d);
    for (int i = 0; i < gap; i++) cycle(1'b0, $urandom_range(0, 255));
  endtask

  // Asserts reset between edges and checks that outputs clear without a clock.
  task automatic async_reset();
    #2;
    i_Reset   = 1'b1;
    i_RxValid = 1'b0;
    model_reset();
    #1;
    chk("rst_we", o_WE, 0);
    chk("rst_addr", o_Addr, 0);
    chk("rst_data", o_Data, 0);
    chk("rst_busy", o_Busy, 0);
    chk("rst_ready", o_RxReady, 0);
    chk("rst_err", o_FrameError, 0);
    @(posedge i_Clock);
    @(negedge i_Clock);
    i_Reset = 1'b0;
    cycle(1'b0, 8'h00);
  endtask

  // Monitor: every strobe must match the head of the queue in the cycle it was due.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_Clock);
      if (!i_Reset) begin
        if (o_WE != 2'b00) begin
          if (q.size() == 0) begin
            chk("unexpected_strobe", {30'd0, o_WE}, 0);
          end else begin
            e = q.pop_front();
            chk("strobe_we", o_WE, e.we);
            chk("strobe_addr", o_Addr, e.addr);
            chk("strobe_data", o_Data, e.data);
            m_last_addr = e.addr;
            m_last_data = e.data;
          end
        end else begin
          chk("missing_strobe", q.size(), 0);
          if (q.size() != 0) begin
            e = q.pop_front();
            m_last_addr = e.addr;
            m_last_data = e.data;
          end
          chk("hold_addr", o_Addr, m_last_addr);
          chk("hold_data", o_Data, m_last_data);
        end
        chk("busy", o_Busy, (m_pos != 0));
        chk("ready", o_RxReady, m_ready);
        chk("frame_err", o_FrameError, m_err);
      end
    end
  end

  initial begin
    i_Reset   = 1'b1;
    i_RxValid = 1'b0;
    i_RxData  = 8'h00;
    model_reset();
    #1;
    chk("init_we", o_WE, 0);
    chk("init_ready", o_RxReady, 0);
    chk("init_busy", o_Busy, 0);
    repeat (2) @(posedge i_Clock);
    @(negedge i_Clock);
    i_Reset = 1'b0;
    cycle(1'b0, 8'h00);

    // Single packet, full rate.
    send(8'h05, 0); send(8'h12, 0); send(8'h34, 0);
    cycle(1'b0, 8'h00); cycle(1'b0, 8'h00);

    // Two packets back-to-back with valid held high.
    send(8'h00, 0); send(8'hFF, 0); send(8'hFF, 0);
    send(8'hFF, 0); send(8'h00, 0); send(8'h01, 0);
    cycle(1'b0, 8'h00);

    // Five-cycle gaps between bytes.
    send(8'h05, 5); send(8'h12, 5); send(8'h34, 5);

    // Reset after the address byte, and again with a strobe just issued.
    send(8'h07, 0);
    async_reset();
    send(8'h09, 0); send(8'hAA, 0); send(8'hBB, 1);
    send(8'h21, 0); send(8'h43, 0);
    async_reset();

    // Stalled packet: 16 idle cycles after the high byte, then 0x04.
    send(8'h03, 0); send(8'h11, 16);
    send(8'h04, 2);
    send(8'h55, 0); send(8'h66, 0);
    async_reset();

    // Randomized traffic with occasional long stalls and resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
      end else if ($urandom_range(0, 99) == 0) begin
        for (int k = 0; k < 20; k++) cycle(1'b0, 8'h00);
      end else begin
        cycle($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)));
      end
    end

    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
